// File: rtl/dma_defs.sv
// Shared DMA definitions: bus/device geometry and controller state encoding.
// Used by the controller, the device model and the CPU-side DMA logic.
package dma_defs;

    localparam int WORD_SIZE      = 16;
    localparam int DEVICE_BIT_LEN = 2;
    localparam int DATA_SIZE      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FETCH,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } dma_state_t;

endpackage

// File: rtl/dma_controller.sv
// DMA sequencer: moves 4-word device blocks into memory under a held bus grant,
// ending each command with a one-cycle dma_end pulse.
module dma_controller #(
    parameter int WORD_SIZE      = dma_defs::WORD_SIZE,
    parameter int DEVICE_BIT_LEN = dma_defs::DEVICE_BIT_LEN,
    parameter int DATA_SIZE      = dma_defs::DATA_SIZE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    input  logic [WORD_SIZE-1:0]      cmd_addr,
    input  logic [WORD_SIZE-1:0]      cmd_length,
    output logic                      cmd_ready,
    output logic                      br,
    input  logic                      bg,
    output logic [DEVICE_BIT_LEN-1:0] offset,
    input  logic [4*WORD_SIZE-1:0]    dev_data,
    output logic                      mem_write,
    output logic [WORD_SIZE-1:0]      mem_addr,
    output logic [4*WORD_SIZE-1:0]    mem_wdata,
    input  logic                      mem_ack,
    output logic                      dma_end
);
    import dma_defs::*;

    localparam int K_W  = $clog2(DATA_SIZE + 1);
    localparam int LB_W = WORD_SIZE - 2;

    // Word count to block count; a partial trailing block is dropped and the
    // result saturates at the device capacity.
    function automatic logic [K_W-1:0] sat_blocks(input logic [WORD_SIZE-1:0] len);
        logic [LB_W-1:0] lb;
        lb = len[WORD_SIZE-1:2];
        if (lb > LB_W'(DATA_SIZE))
            return K_W'(DATA_SIZE);
        return lb[K_W-1:0];
    endfunction

    dma_state_t             r_state;
    dma_state_t             w_state_nxt;
    logic [K_W-1:0]         r_k;
    logic [K_W-1:0]         r_blocks;
    logic [K_W-1:0]         w_k_inc;
    logic [K_W-1:0]         w_blocks;
    logic [WORD_SIZE-1:0]   r_addr;
    logic [4*WORD_SIZE-1:0] r_wdata;
    logic                   w_accept;

    assign w_accept = (r_state == ST_IDLE) && cmd_valid;
    assign w_blocks = sat_blocks(cmd_length);
    assign w_k_inc  = r_k + 1'b1;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid)
                    w_state_nxt = (w_blocks == '0) ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                if (bg)
                    w_state_nxt = ST_FETCH;
            end
            ST_FETCH: w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (mem_ack)
                    w_state_nxt = ST_NEXT;
            end
            // A grant withdrawn mid-block is only honoured here, between blocks.
            ST_NEXT: begin
                if (w_k_inc == r_blocks)
                    w_state_nxt = ST_DONE;
                else if (bg)
                    w_state_nxt = ST_FETCH;
                else
                    w_state_nxt = ST_REQ;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Block index, running write address (wraps modulo 2^WORD_SIZE) and block data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k      <= '0;
            r_blocks <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            if (w_accept) begin
                r_k      <= '0;
                r_blocks <= w_blocks;
                r_addr   <= cmd_addr;
            end
            if (r_state == ST_FETCH)
                r_wdata <= dev_data;
            if (r_state == ST_NEXT) begin
                r_k    <= w_k_inc;
                r_addr <= r_addr + WORD_SIZE'(4);
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign br        = (r_state == ST_REQ) || (r_state == ST_FETCH) ||
                       (r_state == ST_WRITE) || (r_state == ST_NEXT);
    assign mem_write = (r_state == ST_WRITE);
    assign dma_end   = (r_state == ST_DONE);
    assign offset    = DEVICE_BIT_LEN'(r_k);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: cycle-exact checks of the bus handshake,
// block writes, length clamping, grant withdrawal, busy commands and reset abort.
module tb_dma_controller;

    localparam logic [63:0] EXP0 = 64'hD003_D002_D001_D000;
    localparam logic [63:0] EXP1 = 64'hD013_D012_D011_D010;
    localparam logic [63:0] EXP2 = 64'hD023_D022_D021_D020;
    localparam logic [63:0] EXP3 = 64'hD033_D032_D031_D030;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_length;
    logic        cmd_ready;
    logic        br;
    logic        bg;
    logic [1:0]  offset;
    logic [63:0] dev_data;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic        dma_end;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dma_controller dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_addr   (cmd_addr),
        .cmd_length (cmd_length),
        .cmd_ready  (cmd_ready),
        .br         (br),
        .bg         (bg),
        .offset     (offset),
        .dev_data   (dev_data),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .dma_end    (dma_end)
    );

    // Device block store: combinational read by offset.
    always_comb begin
        case (offset)
            2'd0:    dev_data = EXP0;
            2'd1:    dev_data = EXP1;
            2'd2:    dev_data = EXP2;
            default: dev_data = EXP3;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Entered with the DUT in FETCH; returns with the DUT in NEXT.
    task automatic do_block(input logic [1:0] k, input logic [15:0] addr,
                            input logic [63:0] data, input int ack_delay, input bit drop_bg);
        chk("fetch_offset", 64'(offset), 64'(k));
        chk("fetch_mem_write", 64'(mem_write), 64'd0);
        chk("fetch_br", 64'(br), 64'd1);
        tick();
        if (drop_bg) bg = 1'b0;
        chk("write_mem_write", 64'(mem_write), 64'd1);
        chk("write_addr", 64'(mem_addr), 64'(addr));
        chk("write_data", mem_wdata, data);
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            chk("write_hold", 64'(mem_write), 64'd1);
            chk("write_hold_addr", 64'(mem_addr), 64'(addr));
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("next_mem_write", 64'(mem_write), 64'd0);
        chk("next_br", 64'(br), 64'd1);
        chk("next_dma_end", 64'(dma_end), 64'd0);
    endtask

    // Entered in FETCH of block 0 with bg held; immediate acks; checks dma_end timing.
    task automatic run3(input logic [15:0] a);
        do_block(2'd0, a, EXP0, 0, 1'b0);
        tick();
        do_block(2'd1, a + 16'd4, EXP1, 0, 1'b0);
        tick();
        do_block(2'd2, a + 16'd8, EXP2, 0, 1'b0);
        tick();
        chk("done_dma_end", 64'(dma_end), 64'd1);
        chk("done_br", 64'(br), 64'd0);
        chk("done_cmd_ready", 64'(cmd_ready), 64'd0);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] len);
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_length = len;
        tick();
        cmd_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b1; cmd_addr = 16'h1234; cmd_length = 16'd12;
        bg = 1'b1; mem_ack = 1'b1;

        // Reset held two cycles with noisy inputs
        tick();
        bg = 1'b0; mem_ack = 1'b0;
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_br", 64'(br), 64'd0);
        chk("rst_offset", 64'(offset), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_dma_end", 64'(dma_end), 64'd0);
        reset = 1'b0; cmd_valid = 1'b0;
        tick();
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Basic transfer: bg raised two cycles after br, ack one cycle after mem_write
        issue(16'h01F4, 16'd12);
        chk("basic_br_T1", 64'(br), 64'd1);
        chk("basic_cmd_ready_busy", 64'(cmd_ready), 64'd0);
        tick();
        chk("basic_req_wait_mw", 64'(mem_write), 64'd0);
        bg = 1'b1;
        tick();
        do_block(2'd0, 16'h01F4, EXP0, 1, 1'b0);
        tick();
        do_block(2'd1, 16'h01F8, EXP1, 1, 1'b0);
        tick();
        do_block(2'd2, 16'h01FC, EXP2, 1, 1'b0);
        tick();
        chk("basic_dma_end", 64'(dma_end), 64'd1);
        chk("basic_done_br", 64'(br), 64'd0);
        tick();
        chk("basic_end_single", 64'(dma_end), 64'd0);
        chk("basic_after_br", 64'(br), 64'd0);
        chk("basic_after_ready", 64'(cmd_ready), 64'd1);

        // Grant withdrawn during block-0 WRITE
        issue(16'h01F4, 16'd12);
        tick();
        do_block(2'd0, 16'h01F4, EXP0, 0, 1'b1);
        tick();
        chk("gw_req_br", 64'(br), 64'd1);
        chk("gw_req_mw", 64'(mem_write), 64'd0);
        tick();
        chk("gw_req_mw2", 64'(mem_write), 64'd0);
        chk("gw_req_offset", 64'(offset), 64'd1);
        bg = 1'b1;
        tick();
        do_block(2'd1, 16'h01F8, EXP1, 0, 1'b0);
        tick();
        do_block(2'd2, 16'h01FC, EXP2, 0, 1'b0);
        tick();
        chk("gw_dma_end", 64'(dma_end), 64'd1);
        tick();

        // Zero length: dma_end at T+1, no bus request
        bg = 1'b0;
        issue(16'h0500, 16'd0);
        chk("zero_dma_end", 64'(dma_end), 64'd1);
        chk("zero_br", 64'(br), 64'd0);
        tick();
        chk("zero_end_single", 64'(dma_end), 64'd0);
        chk("zero_br_after", 64'(br), 64'd0);
        chk("zero_ready", 64'(cmd_ready), 64'd1);

        // Length 13 -> 3 blocks, bg already high: dma_end at G+10
        bg = 1'b1;
        issue(16'h0040, 16'd13);
        tick();
        run3(16'h0040);
        tick();

        // Length 40 clamped to 3 blocks
        issue(16'h0080, 16'd40);
        tick();
        run3(16'h0080);
        tick();

        // Two blocks wrapping through 0xFFFF
        issue(16'hFFFC, 16'd8);
        tick();
        do_block(2'd0, 16'hFFFC, EXP0, 0, 1'b0);
        tick();
        do_block(2'd1, 16'h0000, EXP1, 0, 1'b0);
        tick();
        chk("wrap_dma_end", 64'(dma_end), 64'd1);
        tick();

        // Busy command ignored
        issue(16'h01F4, 16'd12);
        cmd_valid = 1'b1; cmd_addr = 16'h0300; cmd_length = 16'd4;
        tick();
        chk("busy_cmd_ready", 64'(cmd_ready), 64'd0);
        run3(16'h01F4);
        cmd_valid = 1'b0;
        tick();
        chk("busy_idle_ready", 64'(cmd_ready), 64'd1);
        tick();
        chk("busy_no_restart", 64'(br), 64'd0);

        // Reset during WRITE with mem_ack pending
        issue(16'h0100, 16'd12);
        tick();
        tick();
        chk("rstw_in_write", 64'(mem_write), 64'd1);
        reset = 1'b1; mem_ack = 1'b1;
        tick();
        chk("rstw_br", 64'(br), 64'd0);
        chk("rstw_mem_write", 64'(mem_write), 64'd0);
        chk("rstw_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rstw_dma_end", 64'(dma_end), 64'd0);
        reset = 1'b0; mem_ack = 1'b0;
        tick();
        chk("rstw_no_end", 64'(dma_end), 64'd0);
        chk("rstw_idle", 64'(cmd_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dma_controller.md
# dma_controller

Sequences DMA transfers from the external device's block store into main memory on behalf of the CPU. The CPU issues one command (base address, word count). The controller then:
- requests the memory bus and waits for the grant;
- walks the device's offset port block by block;
- writes each 4-word block to memory;
- signals completion with a one-cycle end pulse.

It sits between the CPU command interface, the bus arbiter (BR/BG), the external device and the memory write port.

## Interface
Parameters:
- WORD_SIZE, 16, memory word width in bits
- DEVICE_BIT_LEN, 2, width of device offset
- DATA_SIZE, 3, number of 4-word blocks the device holds

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  CPU presents a command this cycle
- cmd_addr  in  WORD_SIZE  memory base address (word address)
- cmd_length  in  WORD_SIZE  transfer length in words
- cmd_ready  out  1  controller idle, command accepted when cmd_valid & cmd_ready
- br  out  1  bus request to CPU
- bg  in  1  bus grant from CPU
- offset  out  DEVICE_BIT_LEN  device block select
- dev_data  in  4*WORD_SIZE  device block data for current offset
- mem_write  out  1  memory write strobe, held until mem_ack
- mem_addr  out  WORD_SIZE  block write address
- mem_wdata  out  4*WORD_SIZE  registered block data
- mem_ack  in  1  memory write complete
- dma_end  out  1  one-cycle completion pulse to CPU

## Operation
States: IDLE, REQ, FETCH, WRITE, NEXT, DONE.

IDLE:
- cmd_ready=1.
- On accept, latch base=cmd_addr, k=0, blocks=min(cmd_length>>2, DATA_SIZE). The low 2 bits of cmd_length are ignored.
- If blocks==0 go to DONE; otherwise go to REQ.

REQ:
- br=1.
- When bg is sampled 1, go to FETCH.

FETCH:
- Drive offset=k.
- At the end of the cycle, capture dev_data into mem_wdata. The device data settles within the cycle.
- Go to WRITE.

WRITE:
- mem_write=1, mem_addr=base+4*k, mem_wdata stable.
- When mem_ack is sampled 1, go to NEXT.

NEXT:
- k<=k+1.
- If k+1==blocks, go to DONE.
- Else if bg==1, go to FETCH; else go to REQ.

DONE:
- br=0, dma_end=1 for exactly this cycle, then go to IDLE.

br behaviour:
- br is 1 in REQ, FETCH, WRITE and NEXT, and 0 elsewhere.
- The bus is held for the whole transfer.

Grant withdrawal:
- A bg drop during FETCH or WRITE does not abort the in-flight block. The block completes.
- The drop is only acted on in NEXT, which re-enters REQ.
- Resumption continues at the saved k and address.

Arithmetic:
- mem_addr is computed modulo 2^WORD_SIZE; wrap-around at 0xFFFF is permitted and not flagged.
- k is sized to hold DATA_SIZE.

Command acceptance:
- cmd_valid while not in IDLE is ignored; there is no queueing.
- cmd_ready is 0 in DONE, so a command presented in the dma_end cycle is accepted on the following cycle.

Reset:
- Reset in any state forces IDLE on the next edge.
- Mid-transfer progress is discarded. No dma_end pulse is issued for an aborted transfer.

## Timing
- Reset values: cmd_ready=1, br=0, offset=0, mem_write=0, mem_addr=0, mem_wdata=0, dma_end=0.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Accept at cycle T gives br=1 at T+1.
- bg sampled high at cycle G gives FETCH at G+1 and mem_write=1 at G+2.
- mem_ack sampled at cycle A gives NEXT at A+1, then FETCH at A+2 (bg still high) or DONE at A+2 (last block).
- Per-block cost with an immediate mem_ack: 3 cycles (FETCH, WRITE, NEXT).
- 3-block transfer, bg already high, mem_ack in the first WRITE cycle: dma_end at G+10.
- Zero-length command: dma_end at T+1, br never asserted.
- mem_ack outside WRITE is ignored.

## Structure
- Shared defs package (dma_defs): WORD_SIZE, DEVICE_BIT_LEN, DATA_SIZE, state encoding. The same package is used by the device model and the CPU-side DMA logic.
- No sub-module: a single FSM with an address/block counter. The counter is not worth separating.

## Test plan
- Reset held 2 cycles: all outputs at reset values, cmd_ready=1; bg/mem_ack toggling during reset has no effect.
- Basic transfer: cmd_addr=0x01F4, cmd_length=12, bg raised 2 cycles after br, mem_ack 1 cycle after each mem_write.
  - Writes at 0x01F4/0x01F8/0x01FC with offsets 0/1/2.
  - mem_wdata equals dev_data for each offset.
  - Single dma_end pulse, br=0 after.
- Grant withdrawal: bg dropped during the block-0 WRITE.
  - Block 0 still completes.
  - REQ is entered; no mem_write while bg=0.
  - After bg returns, resumes at 0x01F8 with offset 1.
- Length rules:
  - cmd_length=0 gives dma_end at T+1 with br never high.
  - cmd_length=13 gives 3 blocks.
  - cmd_length=40 is clamped to 3 blocks.
- Reset asserted in WRITE with mem_ack pending: next cycle br=0, mem_write=0, cmd_ready=1, no dma_end.
- Busy command: second cmd_valid (addr 0x0300) during the transfer is ignored; only the original addresses are written.
